imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Program loader: writes a RISC-V program into instruction memory from a byte stream.
//  It is the writer counterpart to the bench-side readout of instruction memory.
//  While a load runs it holds the core in reset. It releases the core once the memory image is written and verified.
//  Sits between a byte source (UART RX / host FIFO) and the mem_instr write port.
// PARAMETERS
//  ADDR_W   5    instruction-memory word-address width (DEPTH = 2**ADDR_W = 32 words)
//  DATA_W   32   instruction word width; fixed at 32 (4 bytes per word)
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse: begin a load; ignored while busy=1
//  rx_data     in   8       incoming byte
//  rx_valid    in   1       rx_data valid
//  rx_ready    out  1       loader accepts byte; transfer when rx_valid&&rx_ready
//  imem_we     out  1       instruction-memory write strobe, 1 cycle per word
//  imem_addr   out  ADDR_W  word address being written
//  imem_wdata  out  32      word being written
//  core_reset  out  1       active-high hold of processor reset during load
//  busy        out  1       load in progress (state not IDLE/DONE/ERR)
//  done        out  1       1-cycle pulse: load completed, checksum OK
//  error       out  1       level: bad count or checksum; cleared by next start
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE. All outputs=0, word/byte counters=0, checksum=0.
//  Frame: COUNT byte N, then N words of 4 bytes, little-endian (first byte -> [7:0]), then CHK byte.
//  CHK = XOR of all 4*N data bytes. N is not included in the checksum.
//  FSM states:
//   IDLE : rx_ready=0. On start -> COUNT; core_reset<=1, error<=0, addr<=0, chk<=0.
//   COUNT: rx_ready=1. On a byte: N==0 or N>DEPTH -> ERR, else store N -> DATA.
//   DATA : rx_ready=1. Each byte shifts into the word buffer at lane byte_cnt and XORs into chk.
//          On the 4th byte -> WRITE.
//   WRITE: rx_ready=0 for exactly 1 cycle. imem_we=1, with imem_addr=word_cnt and imem_wdata=buffer.
//          Then word_cnt+1. Go to DATA if words remain, else CHECK.
//   CHECK: rx_ready=1. On a byte: equal to chk -> DONE, else -> ERR.
//   DONE : done=1 for 1 cycle, core_reset<=0 -> IDLE.
//   ERR  : error<=1, core_reset stays 1 (the core never runs a bad image) -> IDLE.
//  Only IDLE reacts to start. A start in any other state is ignored.
//  Latency: last CHK byte accepted at edge k; done=1 and core_reset=0 in cycle k+1.
//  Gaps: rx_valid=0 for any number of cycles stalls the FSM with no state change. There is no timeout.
//  Writes stop at word N-1. Addresses never wrap. Memory words >= N keep old contents.
//  A failed CHK does not undo words already written; core_reset=1 protects the core.
//  busy=1 in COUNT/DATA/WRITE/CHECK.
//  imem_addr/imem_wdata are valid only when imem_we=1. Between writes they hold their last value.
//  Reset mid-load: FSM returns to IDLE at once and core_reset drops to 0.
//   A partially written image may then run. The system reset sequencer must reissue start.
// TESTING
//  1 Reset: reset=0 mid-DATA -> all outputs 0 immediately. After release, start is accepted again.
//  2 Happy path: start; N=2; words 0x00500093,0x00A00113 (LSB first); CHK=XOR of the 8 bytes
//    -> imem_we at addr 0 then 1 with those words; done pulse 1 cycle after CHK;
//    core_reset 1->0 at done.
//  3 Stalls: same frame with rx_valid deasserted 3 cycles between every byte -> identical writes/result.
//    rx_ready=0 exactly on WRITE cycles.
//  4 Bad count: N=0 and separately N=33 -> error=1, no imem_we, core_reset stays 1.
//    A new start clears error.
//  5 Bad checksum: N=1, CHK wrong -> word written at addr 0, error=1, done never pulses, core_reset=1.
//  6 Full depth: N=32 with words 0..31 -> addresses 0..31 written in order, no wrap.
//    A start pulsed mid-load is ignored; done=1 at end.

Source files
------------

// File: rtl/imem_loader.sv
// Program loader: receives COUNT/words/CHK byte frames and writes them into instruction memory.
// The core is held in reset while a load runs and is released only after the checksum matches.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [DATA_W-1:0] imem_wdata_o,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [8:0] DEPTH_B = 9'(1 << ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    word_cnt_q;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         buf_q;
    logic [7:0]          chk_q;
    logic                rx_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [DATA_W-1:0]   imem_wdata_q;
    logic                core_reset_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic                accept;
    logic                count_bad;
    logic [CNT_W-1:0]    word_cnt_d;
    logic [DATA_W-1:0]   word_d;

    assign accept     = rx_valid_i & rx_ready_q;
    assign count_bad  = (rx_data_i == 8'd0) || ({1'b0, rx_data_i} > DEPTH_B);
    assign word_cnt_d = word_cnt_q + 1'b1;
    // Lanes 0..2 are already buffered; the byte arriving now is lane 3.
    assign word_d     = {rx_data_i, buf_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            word_cnt_q   <= '0;
            byte_cnt_q   <= '0;
            buf_q        <= '0;
            chk_q        <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_COUNT;
                        core_reset_q <= 1'b1;
                        error_q      <= 1'b0;
                        word_cnt_q   <= '0;
                        byte_cnt_q   <= '0;
                        chk_q        <= '0;
                        rx_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        if (count_bad) begin
                            state_q    <= S_ERR;
                            error_q    <= 1'b1;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                        end else begin
                            n_q     <= rx_data_i[CNT_W-1:0];
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        chk_q      <= chk_q ^ rx_data_i;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            rx_ready_q   <= 1'b0;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                            imem_wdata_q <= word_d;
                        end else begin
                            buf_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_i;
                        end
                    end
                end
                S_WRITE: begin
                    imem_we_q  <= 1'b0;
                    word_cnt_q <= word_cnt_d;
                    byte_cnt_q <= '0;
                    rx_ready_q <= 1'b1;
                    state_q    <= (word_cnt_d == n_q) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data_i == chk_q) begin
                            state_q      <= S_DONE;
                            done_q       <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ERR: begin
                    // core_reset_q stays high so a corrupt image never runs.
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign core_reset_o = core_reset_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random frames checked against a memory-image model.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [4:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        core_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    imem_loader #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_wdata_o(imem_wdata_o),
        .core_reset_o(core_reset_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          hs_viol = 0;
    logic [4:0]  wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] obs_mem[32];
    logic [31:0] model_mem[32];
    logic [31:0] frame_words[32];

    // Monitor: captures writes and checks rx_ready is low exactly on write cycles.
    always @(negedge clk_i) begin
        if (imem_we_o) begin
            wq_addr.push_back(imem_addr_o);
            wq_data.push_back(imem_wdata_o);
            obs_mem[imem_addr_o] = imem_wdata_o;
        end
        if (done_o) done_cnt++;
        if (busy_o ? (rx_ready_o !== !imem_we_o) : (rx_ready_o !== 1'b0)) hs_viol++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk_i);
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        t = 0;
        while (!rx_ready_o && t < 64) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 64) begin
            check("rx_ready_timeout", rx_ready_o, 1);
            rx_valid_i = 1'b0;
        end else begin
            @(posedge clk_i);
            #1 rx_valid_i = 1'b0;
        end
    endtask

    task automatic run_frame(input int n, input int gap, input bit bad, input int start_at,
                             input bit do_start);
        int         d0;
        int         mm;
        logic [7:0] chk;
        logic [7:0] b;
        d0 = done_cnt;
        chk = 8'h00;
        hs_viol = 0;
        wq_addr.delete();
        wq_data.delete();
        if (do_start) pulse_start();
        check("load_core_reset", core_reset_o, 1);
        check("load_busy", busy_o, 1);
        send_byte(8'(n), gap);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k == start_at) begin
                    pulse_start();
                    check("ignored_start_busy", busy_o, 1);
                end
                b = frame_words[w][8*k +: 8];
                chk ^= b;
                send_byte(b, gap);
            end
            model_mem[w] = frame_words[w];
        end
        if (bad) send_byte(chk ^ 8'($urandom_range(1, 255)), gap);
        else     send_byte(chk, gap);
        if (!bad) begin
            check("done_latency", done_o, 1);
            check("core_release", core_reset_o, 0);
        end else begin
            check("bad_chk_no_done", done_o, 0);
            check("bad_chk_error", error_o, 1);
        end
        repeat (3) @(negedge clk_i);
        check("done_pulses", done_cnt - d0, bad ? 0 : 1);
        check("end_core_reset", core_reset_o, bad ? 1 : 0);
        check("end_error", error_o, bad ? 1 : 0);
        check("end_busy", busy_o, 0);
        check("write_count", wq_addr.size(), n);
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            check("write_addr", wq_addr[i], i);
            check("write_data", wq_data[i], frame_words[i]);
        end
        mm = 0;
        for (int i = 0; i < 32; i++) if (obs_mem[i] !== model_mem[i]) mm++;
        check("memory_image", mm, 0);
        check("rx_ready_vs_write", hs_viol, 0);
    endtask

    task automatic bad_count(input logic [7:0] n);
        wq_addr.delete();
        pulse_start();
        send_byte(n, 0);
        repeat (2) @(negedge clk_i);
        check("badcnt_error", error_o, 1);
        check("badcnt_core_reset", core_reset_o, 1);
        check("badcnt_busy", busy_o, 0);
        check("badcnt_no_write", wq_addr.size(), 0);
        pulse_start();
        check("start_clears_error", error_o, 0);
        check("restart_core_reset", core_reset_o, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 32; i++) begin
            obs_mem[i]   = 32'h0;
            model_mem[i] = 32'h0;
        end
        rst_n_i = 1'b0; start_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = 8'h00;
        #12;
        check("reset_outputs", {rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
                                core_reset_o, busy_o, done_o, error_o}, 0);
        @(negedge clk_i); rst_n_i = 1'b1;

        frame_words[0] = 32'h00500093;
        frame_words[1] = 32'h00A00113;
        run_frame(2, 0, 1'b0, -1, 1'b1);
        run_frame(2, 3, 1'b0, -1, 1'b1);

        bad_count(8'd0);
        frame_words[0] = $urandom;
        run_frame(1, 0, 1'b0, -1, 1'b0);
        bad_count(8'd33);
        frame_words[0] = $urandom;
        frame_words[1] = $urandom;
        run_frame(2, 1, 1'b0, -1, 1'b0);

        frame_words[0] = $urandom;
        run_frame(1, 0, 1'b1, -1, 1'b1);

        for (int i = 0; i < 32; i++) frame_words[i] = {$urandom_range(0, 16'hFFFF), 16'(i)};
        run_frame(32, 0, 1'b0, 50, 1'b1);

        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(1, 32);
            for (int i = 0; i < 32; i++) frame_words[i] = $urandom;
            run_frame(n, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), -1, 1'b1);
        end

        // Reset in the middle of a word: everything clears asynchronously.
        pulse_start();
        send_byte(8'd4, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("midload_reset_outputs", {rx_ready_o, imem_we_o, imem_addr_o, imem_wdata_o,
                                        core_reset_o, busy_o, done_o, error_o}, 0);
        #10 rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) frame_words[i] = $urandom;
        run_frame(3, 1, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
